// File: rtl/pb_debounce.sv
// pb_debounce: per-channel 2-flop synchroniser, debounce FSM, registered pulses.
// Optional auto-repeat on held buttons: define DEBOUNCE_REPEAT_EN.
module pb_debounce #(
   parameter int N_BTN           = 3,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] pb_in,
   output logic [N_BTN-1:0] pb_level,
   output logic [N_BTN-1:0] pb_press,
   output logic [N_BTN-1:0] pb_release
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      ARM,
      HELD,
      DISARM
   } state_t;

   logic [N_BTN-1:0] meta;
   logic [N_BTN-1:0] sync;

   // two-flop synchroniser; nothing else looks at pb_in
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta <= '0;
         sync <= '0;
      end else begin
         meta <= pb_in;
         sync <= meta;
      end
   end

   for (genvar ch = 0; ch < N_BTN; ch++) begin : g_ch
      state_t          st, st_n;
      logic [CW-1:0]   cnt, cnt_n;
      logic            lvl, lvl_n;
      logic            prs, prs_n;
      logic            rel, rel_n;
`ifdef DEBOUNCE_REPEAT_EN
      localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                            REPEAT_DELAY : REPEAT_PERIOD;
      localparam int RW = $clog2(RMAX) + 1;
      localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
      localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);
      logic [RW-1:0]   rcnt, rcnt_n;
      logic            rrep, rrep_n;
`endif

      // next state, stability counter and pulse decisions
      always_comb begin
         st_n  = st;
         cnt_n = cnt;
         lvl_n = lvl;
         prs_n = 1'b0;
         rel_n = 1'b0;
         unique case (st)
            IDLE: begin
               if (sync[ch]) begin
                  st_n  = ARM;
                  cnt_n = CW'(1);
               end
            end
            ARM: begin
               if (!sync[ch]) begin
                  st_n  = IDLE;
                  cnt_n = '0;
               end else if (cnt == LAST) begin
                  st_n  = HELD;
                  cnt_n = '0;
                  lvl_n = 1'b1;
                  prs_n = 1'b1;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
            HELD: begin
               if (!sync[ch]) begin
                  st_n  = DISARM;
                  cnt_n = CW'(1);
               end
            end
            DISARM: begin
               if (sync[ch]) begin
                  st_n  = HELD;
                  cnt_n = '0;
               end else if (cnt == LAST) begin
                  st_n  = IDLE;
                  cnt_n = '0;
                  lvl_n = 1'b0;
                  rel_n = 1'b1;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
            default: begin
               st_n  = IDLE;
               cnt_n = '0;
            end
         endcase
`ifdef DEBOUNCE_REPEAT_EN
         rcnt_n = rcnt;
         rrep_n = rrep;
         if (st == ARM && st_n == HELD) begin
            rcnt_n = '0;
            rrep_n = 1'b0;
         end else if ((st == HELD || st == DISARM) &&
                      (st_n == HELD || st_n == DISARM)) begin
            if (rcnt == (rrep ? RP_LAST : RD_LAST)) begin
               prs_n  = 1'b1;
               rcnt_n = '0;
               rrep_n = 1'b1;
            end else begin
               rcnt_n = rcnt + 1'b1;
            end
         end else begin
            rcnt_n = '0;
            rrep_n = 1'b0;
         end
`endif
      end

      // per-channel state and registered outputs
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            st  <= IDLE;
            cnt <= '0;
            lvl <= 1'b0;
            prs <= 1'b0;
            rel <= 1'b0;
`ifdef DEBOUNCE_REPEAT_EN
            rcnt <= '0;
            rrep <= 1'b0;
`endif
         end else begin
            st  <= st_n;
            cnt <= cnt_n;
            lvl <= lvl_n;
            prs <= prs_n;
            rel <= rel_n;
`ifdef DEBOUNCE_REPEAT_EN
            rcnt <= rcnt_n;
            rrep <= rrep_n;
`endif
         end
      end

      assign pb_level[ch]   = lvl;
      assign pb_press[ch]   = prs;
      assign pb_release[ch] = rel;
   end

endmodule

// File: tb/tb_pb_debounce.sv
// tb_pb_debounce: directed + random stimulus against a streak-count model.
// Pass DEBOUNCE_REPEAT_EN to both bench and RTL to cover auto-repeat.
module tb_pb_debounce;

   localparam int N  = 3;
   localparam int D  = 8;
   localparam int RD = 40;
   localparam int RP = 10;
`ifdef DEBOUNCE_REPEAT_EN
   localparam bit REP = 1'b1;
`else
   localparam bit REP = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] pb_in;
   logic [N-1:0] pb_level;
   logic [N-1:0] pb_press;
   logic [N-1:0] pb_release;

   int n_chk  = 0;
   int n_fail = 0;
   int pc[N];
   int rc[N];

   pb_debounce #(
      .N_BTN(N),
      .DEBOUNCE_CYCLES(D),
      .REPEAT_DELAY(RD),
      .REPEAT_PERIOD(RP)
   ) dut (
      .clk(clk),
      .rst(rst),
      .pb_in(pb_in),
      .pb_level(pb_level),
      .pb_press(pb_press),
      .pb_release(pb_release)
   );

   always #10 clk = ~clk;

   // reference: a change is accepted after D consecutive synced samples
   // that disagree with the current level; repeat counts cycles held
   logic [N-1:0] m_s1, m_s2, m_lvl, m_press, m_rel;
   int m_streak[N];
   int m_k[N];

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_s1 = '0; m_s2 = '0; m_lvl = '0;
         m_press = '0; m_rel = '0;
         for (int c = 0; c < N; c++) begin
            m_streak[c] = 0;
            m_k[c] = 0;
         end
      end else begin
         m_press = '0;
         m_rel = '0;
         for (int c = 0; c < N; c++) begin
            bit flip;
            flip = 1'b0;
            if (m_s2[c] != m_lvl[c]) begin
               m_streak[c]++;
               flip = (m_streak[c] == D);
            end else begin
               m_streak[c] = 0;
            end
            if (flip) begin
               m_streak[c] = 0;
               m_lvl[c] = ~m_lvl[c];
               if (m_lvl[c]) begin
                  m_press[c] = 1'b1;
                  m_k[c] = 0;
               end else begin
                  m_rel[c] = 1'b1;
               end
            end else if (m_lvl[c]) begin
               m_k[c]++;
               if (REP && (m_k[c] == RD ||
                   (m_k[c] > RD && (m_k[c] - RD) % RP == 0)))
                  m_press[c] = 1'b1;
            end
         end
         m_s2 = m_s1;
         m_s1 = pb_in;
      end
   end

   task automatic step();
      @(negedge clk);
      n_chk++;
      assert (pb_level === m_lvl) else begin
         n_fail++;
         $error("FAIL level: got %b exp %b", pb_level, m_lvl);
      end
      n_chk++;
      assert (pb_press === m_press) else begin
         n_fail++;
         $error("FAIL press: got %b exp %b", pb_press, m_press);
      end
      n_chk++;
      assert (pb_release === m_rel) else begin
         n_fail++;
         $error("FAIL release: got %b exp %b", pb_release, m_rel);
      end
      n_chk++;
      assert ((pb_press & pb_release) === '0) else begin
         n_fail++;
         $error("FAIL excl: got %b exp 000", pb_press & pb_release);
      end
      for (int c = 0; c < N; c++) begin
         if (pb_press[c] === 1'b1) pc[c]++;
         if (pb_release[c] === 1'b1) rc[c]++;
      end
   endtask

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0d exp %0d", tag, got, exp);
      end
   endtask

   task automatic clr();
      for (int c = 0; c < N; c++) begin
         pc[c] = 0;
         rc[c] = 0;
      end
   endtask

   initial begin
      int at, at2, hits;
      int q[$];
      int run[N];

      rst = 1'b1;
      pb_in = '0;
      clr();
      #5 rst = 1'b0;

      // reset state
      step();
      step();
      chk("rst_level", int'(pb_level), 0);
      chk("rst_press", int'(pb_press), 0);
      chk("rst_rel", int'(pb_release), 0);
      rst = 1'b1;
      repeat (4) step();

      // clean press / release on PB0
      clr();
      pb_in[0] = 1'b1;
      at = 0;
      for (int i = 1; i <= 30; i++) begin
         step();
         if (pb_level[0] === 1'b1 && at == 0) at = i;
      end
      chk("clean_rise_step", at, 10);
      pb_in[0] = 1'b0;
      at2 = 0;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (pb_release[0] === 1'b1 && at2 == 0) at2 = i;
      end
      chk("clean_rel_step", at2, 10);
      chk("clean_press_cnt", pc[0], 1);
      chk("clean_rel_cnt", rc[0], 1);

      // bounce on PB1: 3-cycle phases for 20 cycles then high
      clr();
      for (int i = 0; i < 45; i++) begin
         pb_in[1] = (i >= 20) ? 1'b1 : (((i / 3) % 2) == 0);
         step();
      end
      chk("bounce_press_cnt", pc[1], 1);
      chk("bounce_level", int'(pb_level[1]), 1);
      pb_in[1] = 1'b0;
      repeat (15) step();
      chk("bounce_rel_cnt", rc[1], 1);

      // near-miss: PB2 high for 6 cycles
      clr();
      pb_in[2] = 1'b1;
      repeat (6) step();
      pb_in[2] = 1'b0;
      at = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (pb_level[2] === 1'b1) at = 1;
      end
      chk("glitch_level", at, 0);
      chk("glitch_press", pc[2], 0);

      // reset mid-count on PB0 (count reaches 5 after 7th edge)
      clr();
      pb_in[0] = 1'b1;
      repeat (7) step();
      rst = 1'b0;
      #1;
      chk("midrst_out", int'({pb_level, pb_press, pb_release}), 0);
      step();
      chk("midrst_out2", int'({pb_level, pb_press, pb_release}), 0);
      step();
      rst = 1'b1;
      at = 0;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (pb_press[0] === 1'b1 && at == 0) at = i;
      end
      chk("midrst_press_step", at, 10);
      chk("midrst_press_cnt", pc[0], 1);
      chk("midrst_rel_cnt", rc[0], 0);
      pb_in[0] = 1'b0;
      repeat (15) step();

      // simultaneous presses on all channels
      clr();
      pb_in = '1;
      at = 0;
      hits = 0;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (pb_press === 3'b111) begin
            at = i;
            hits++;
         end
      end
      chk("simul_step", at, 10);
      chk("simul_hits", hits, 1);
      chk("simul_level", int'(pb_level), 7);
      pb_in = '0;
      repeat (15) step();

      // held PB0 for 75 cycles past acceptance
      clr();
      pb_in[0] = 1'b1;
      for (int i = 1; i <= 85; i++) begin
         step();
         if (pb_press[0] === 1'b1) q.push_back(i);
      end
      chk("rep_cnt", q.size(), REP ? 5 : 1);
      if (q.size() > 0) chk("rep_first", q[0], 10);
      if (REP && q.size() == 5) begin
         chk("rep_2", q[1], 50);
         chk("rep_3", q[2], 60);
         chk("rep_4", q[3], 70);
         chk("rep_5", q[4], 80);
      end
      pb_in[0] = 1'b0;
      repeat (15) step();

      // random runs on all channels, one reset pulse midway
      for (int c = 0; c < N; c++) run[c] = $urandom_range(1, 14);
      for (int i = 0; i < 800; i++) begin
         for (int c = 0; c < N; c++) begin
            run[c]--;
            if (run[c] <= 0) begin
               pb_in[c] = ~pb_in[c];
               run[c] = $urandom_range(1, 14);
            end
         end
         if (i == 400) rst = 1'b0;
         if (i == 402) rst = 1'b1;
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
